// File: rtl/fetch_if.sv
// Fetch-stage bus: PC/ROM/hazard inputs and PC-control/F-D latch outputs.
// The master side is the fetch stage; the slave side is the PC, ROM and pipeline around it.
interface fetch_if #(
    parameter int IW = 32,
    parameter int AW = 12
);
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_prev;
    logic [IW-1:0] imem_q;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] pc_next;
    logic          pc_en;
    logic          imem_en;
    logic          fd_valid;
    logic [IW-1:0] fd_insn;
    logic [AW-1:0] fd_pc;
    logic [AW-1:0] fd_pc_plus1;

    modport master (
        input  pc_out, pc_prev, imem_q, stall, redirect_valid, redirect_target,
        output pc_next, pc_en, imem_en, fd_valid, fd_insn, fd_pc, fd_pc_plus1
    );

    modport slave (
        output pc_out, pc_prev, imem_q, stall, redirect_valid, redirect_target,
        input  pc_next, pc_en, imem_en, fd_valid, fd_insn, fd_pc, fd_pc_plus1
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch control: next-PC/enable, ROM gating and the F/D latch with reset/redirect bubbles.
// Optional FETCH_HALT_DETECT_EN adds a HALTED state entered on a valid 5'b11110 opcode.
module fetch_stage #(
    parameter int IW = 32,
    parameter int AW = 12
) (
    input  logic     clk,
    input  logic     clr,
    fetch_if.master  bus
);
    // state   | meaning
    // FILL    | first cycle after reset, ROM output not yet valid
    // RUN     | ROM output belongs to the current path
    // SQUASH  | ROM output is a wrong-path word after a redirect
    // HALTED  | halt opcode latched, fetch frozen until redirect (macro only)
    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2
`ifdef FETCH_HALT_DETECT_EN
        ,
        S_HALTED = 2'd3
`endif
    } state_t;

    state_t        state_q;
    logic          fd_valid_q;
    logic [IW-1:0] fd_insn_q;
    logic [AW-1:0] fd_pc_q;
    logic [AW-1:0] fd_pc_plus1_q;

    logic          halted;
    logic          pc_en;
    logic          load_valid;

`ifdef FETCH_HALT_DETECT_EN
    logic          is_halt;
    assign halted  = (state_q == S_HALTED);
    assign is_halt = (bus.imem_q[IW-1 -: 5] == 5'b11110);
`else
    assign halted  = 1'b0;
`endif

    // A redirect overrides both stall and halt so the PC can always be steered.
    assign pc_en       = bus.redirect_valid | (~bus.stall & ~halted);
    assign load_valid  = (state_q == S_RUN) & ~bus.redirect_valid;

    assign bus.pc_en   = pc_en;
    assign bus.imem_en = pc_en;
    assign bus.pc_next = bus.redirect_valid ? bus.redirect_target
                                            : bus.pc_out + AW'(1);

    assign bus.fd_valid    = fd_valid_q;
    assign bus.fd_insn     = fd_insn_q;
    assign bus.fd_pc       = fd_pc_q;
    assign bus.fd_pc_plus1 = fd_pc_plus1_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= S_FILL;
            fd_valid_q    <= 1'b0;
            fd_insn_q     <= '0;
            fd_pc_q       <= '0;
            fd_pc_plus1_q <= '0;
        end else if (pc_en) begin
            fd_valid_q    <= load_valid;
            fd_insn_q     <= bus.imem_q;
            fd_pc_q       <= bus.pc_prev;
            fd_pc_plus1_q <= bus.pc_prev + AW'(1);
            if (bus.redirect_valid) begin
                state_q <= S_SQUASH;
            end else begin
                case (state_q)
                    S_FILL:   state_q <= S_RUN;
                    S_SQUASH: state_q <= S_RUN;
`ifdef FETCH_HALT_DETECT_EN
                    S_RUN:    state_q <= is_halt ? S_HALTED : S_RUN;
`else
                    S_RUN:    state_q <= S_RUN;
`endif
                    default:  state_q <= state_q;
                endcase
            end
`ifdef FETCH_HALT_DETECT_EN
        end else if (halted) begin
            // Halt instruction stays valid for exactly one cycle, then bubbles.
            fd_valid_q <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural PC register and synchronous ROM.
module tb_fetch_stage;
    localparam int IW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.IW(IW), .AW(AW)) bus ();

    fetch_stage #(.IW(IW), .AW(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 12'h200) return 32'hF000_0200;
        return 32'h1000_0000 + {20'd0, a};
    endfunction

    // Behavioural program counter and synchronous ROM around the DUT.
    logic [AW-1:0] pc_q, pc_prev_q;
    logic [IW-1:0] rom_q;
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q      <= '0;
            pc_prev_q <= '0;
            rom_q     <= '0;
        end else if (bus.pc_en) begin
            pc_q      <= bus.pc_next;
            pc_prev_q <= pc_q;
            rom_q     <= rom_word(pc_q);
        end
    end

    logic          tbl_mode = 1'b1;
    logic [AW-1:0] tbl_pc   = '0;
    assign bus.pc_out  = tbl_mode ? tbl_pc : pc_q;
    assign bus.pc_prev = pc_prev_q;
    assign bus.imem_q  = rom_q;

    typedef struct {
        logic [AW-1:0] pc;
        logic          stall;
        logic          rv;
        logic [AW-1:0] tgt;
        logic [AW-1:0] exp_next;
        logic          exp_en;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, ".valid"}, {31'd0, bus.fd_valid}, 32'd0);
    endtask

    task automatic chk_fd(input string name, input logic [AW-1:0] pc);
        chk({name, ".valid"}, {31'd0, bus.fd_valid}, 32'd1);
        chk({name, ".pc"}, {20'd0, bus.fd_pc}, {20'd0, pc});
        chk({name, ".pc1"}, {20'd0, bus.fd_pc_plus1}, {20'd0, pc + 12'd1});
        chk({name, ".insn"}, bus.fd_insn, rom_word(pc));
    endtask

    initial begin
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;

        vecs[0] = '{12'h000, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1};
        vecs[1] = '{12'h7FF, 1'b0, 1'b0, 12'h000, 12'h800, 1'b1};
        vecs[2] = '{12'hFFF, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1};
        vecs[3] = '{12'h123, 1'b1, 1'b0, 12'h000, 12'h124, 1'b0};
        vecs[4] = '{12'h123, 1'b1, 1'b1, 12'h100, 12'h100, 1'b1};
        vecs[5] = '{12'h123, 1'b0, 1'b1, 12'hABC, 12'hABC, 1'b1};
        vecs[6] = '{12'hFFF, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0};
        vecs[7] = '{12'h055, 1'b0, 1'b1, 12'hFFF, 12'hFFF, 1'b1};

        // Combinational next-PC/enable table, state held in FILL by reset.
        #12;
        for (int i = 0; i < 8; i++) begin
            tbl_pc              = vecs[i].pc;
            bus.stall           = vecs[i].stall;
            bus.redirect_valid  = vecs[i].rv;
            bus.redirect_target = vecs[i].tgt;
            #1;
            chk($sformatf("tbl%0d.pc_next", i), {20'd0, bus.pc_next}, {20'd0, vecs[i].exp_next});
            chk($sformatf("tbl%0d.pc_en", i), {31'd0, bus.pc_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("tbl%0d.imem_en", i), {31'd0, bus.imem_en}, {31'd0, vecs[i].exp_en});
        end
        tbl_mode            = 1'b0;
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        #1;
        chk("rst.valid", {31'd0, bus.fd_valid}, 32'd0);
        chk("rst.insn", bus.fd_insn, 32'd0);
        chk("rst.pc", {20'd0, bus.fd_pc}, 32'd0);
        chk("rst.pc1", {20'd0, bus.fd_pc_plus1}, 32'd0);
        chk("rst.pc_next", {20'd0, bus.pc_next}, 32'd1);
        chk("rst.pc_en", {31'd0, bus.pc_en}, 32'd1);

        // Reset release: one FILL bubble, then sequential fetch.
        @(negedge clk);
        clr = 1'b0;
        step();
        chk_bubble("fill");
        for (int k = 0; k <= 5; k++) begin
            step();
            chk_fd($sformatf("seq%0d", k), 12'(k));
        end

        // Stall for 3 cycles while fd_pc=5.
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d.pc_en", k), {31'd0, bus.pc_en}, 32'd0);
            step();
            chk_fd($sformatf("stall%0d", k), 12'h005);
        end
        bus.stall = 1'b0;
        step();
        chk_fd("unstall", 12'h006);
        step();
        chk_fd("seq7", 12'h007);

        // Redirect to 0x040.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h040;
        step();
        bus.redirect_valid = 1'b0;
        chk_bubble("redir.b1");
        step();
        chk_bubble("redir.b2");
        step();
        chk_fd("redir.tgt", 12'h040);

        // Stall and redirect together: redirect wins.
        bus.stall           = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h100;
        #1;
        chk("sr.pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("sr.pc_next", {20'd0, bus.pc_next}, 32'h100);
        step();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        chk_bubble("sr.b1");
        step();
        chk_bubble("sr.b2");
        step();
        chk_fd("sr.tgt", 12'h100);

        // Address wrap at 0xFFF.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'hFFE;
        step();
        bus.redirect_valid = 1'b0;
        chk_bubble("wrap.b1");
        step();
        chk_bubble("wrap.b2");
        chk("wrap.pc_next", {20'd0, bus.pc_next}, 32'h000);
        step();
        chk_fd("wrap.ffe", 12'hFFE);
        step();
        chk_fd("wrap.fff", 12'hFFF);
        step();
        chk_fd("wrap.000", 12'h000);

        // Back-to-back redirects: only the last target becomes valid.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h080;
        step();
        chk_bubble("b2b.b1");
        bus.redirect_target = 12'h0C0;
        step();
        bus.redirect_valid = 1'b0;
        chk_bubble("b2b.b2");
        step();
        chk_bubble("b2b.b3");
        step();
        chk_fd("b2b.tgt", 12'h0C0);

        // Asynchronous clear between edges.
        #1;
        clr = 1'b1;
        #1;
        chk("aclr.valid", {31'd0, bus.fd_valid}, 32'd0);
        chk("aclr.pc", {20'd0, bus.fd_pc}, 32'd0);
        chk("aclr.insn", bus.fd_insn, 32'd0);
        clr = 1'b0;
        step();
        chk_bubble("aclr.fill");
        step();
        chk_fd("aclr.first", 12'h000);

        // Halt opcode at 0x200.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h1FE;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk_fd("halt.1fe", 12'h1FE);
        step();
        chk_fd("halt.1ff", 12'h1FF);
        step();
        chk_fd("halt.200", 12'h200);
`ifdef FETCH_HALT_DETECT_EN
        chk("halt.pc_en", {31'd0, bus.pc_en}, 32'd0);
        step();
        chk_bubble("halt.h1");
        step();
        chk_bubble("halt.h2");
        chk("halt.frozen", {20'd0, bus.pc_out}, 32'h202);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h010;
        #1;
        chk("halt.redir_en", {31'd0, bus.pc_en}, 32'd1);
        step();
        bus.redirect_valid = 1'b0;
        chk_bubble("halt.r1");
        step();
        chk_bubble("halt.r2");
        step();
        chk_fd("halt.resume", 12'h010);

        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'h200;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk_fd("halt2.200", 12'h200);
        step();
        chk_bubble("halt2.h1");
        #1;
        clr = 1'b1;
        #1;
        clr = 1'b0;
        chk("halt2.clr_en", {31'd0, bus.pc_en}, 32'd1);
        chk("halt2.clr_next", {20'd0, bus.pc_next}, 32'h001);
        step();
        chk_bubble("halt2.fill");
        step();
        chk_fd("halt2.first", 12'h000);
`else
        chk("nohalt.pc_en", {31'd0, bus.pc_en}, 32'd1);
        step();
        chk_fd("nohalt.201", 12'h201);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
